// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 index tables, shift schedule,
// widths, controller state type and 28-bit rotate helpers.
package des_pkg;

    localparam int KEY_W      = 64;
    localparam int CD_W       = 56;
    localparam int SK_W       = 48;
    localparam int HALF_W     = 28;
    localparam int NUM_ROUNDS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Entries are 1-based DES bit numbers; the first listed entry lands on the output MSB.
    localparam logic [CD_W-1:0][7:0] PC1_TBL = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
        8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
        8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
        8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
        8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
        8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
        8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
    };

    localparam logic [SK_W-1:0][7:0] PC2_TBL = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
        8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
        8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
        8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
        8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
        8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
        8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
    };

    // Bit r-1 set means round r shifts by one (rounds 1, 2, 9, 16); all others shift by two.
    localparam logic [NUM_ROUNDS-1:0] SHIFT1_TBL = 16'h8103;

    function automatic logic [1:0] shift_amt(input logic [3:0] idx);
        return SHIFT1_TBL[idx] ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

endpackage

// File: rtl/des_pc_perm.sv
// Combinational bit permutation driven by a table of 1-based source bit numbers
// (bit 1 = din MSB); the table entry at index o selects dout[o].
module des_pc_perm #(
    parameter int                         IN_W  = 64,
    parameter int                         OUT_W = 56,
    parameter logic [OUT_W-1:0][7:0]      TBL   = {OUT_W{8'd1}}
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    for (genvar o = 0; o < OUT_W; o++) begin : g_bit
        assign dout[o] = din[IN_W - int'(TBL[o])];
    end

endmodule

// File: rtl/des_key_scheduler.sv
// Sequential DES key schedule: one 48-bit subkey per handshake, encrypt or decrypt order.
// Optional key parity rejection with a key_err pulse under DES_KEY_PARITY_CHECK_EN.
module des_key_scheduler
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS_P = NUM_ROUNDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             decrypt,
    output logic             sk_valid,
    input  logic             sk_ready,
    output logic [SK_W-1:0]  sk_out,
    output logic [3:0]       sk_round,
    output logic             sk_last,
`ifdef DES_KEY_PARITY_CHECK_EN
    output logic             key_err,
`endif
    output logic             busy
);

    state_e            state_q, state_d;
    logic [CD_W-1:0]   cd_q, cd_d, cd0;
    logic [3:0]        cnt_q, cnt_d, nxt;
    logic              mode_q, mode_d;
    logic              sk_valid_q, sk_valid_d;
    logic [SK_W-1:0]   sk_out_q, sk_out_d, sk_next;
    logic [3:0]        sk_round_q, sk_round_d;
    logic              sk_last_q, sk_last_d;
    logic              upd;
    logic              key_ok;

    function automatic logic [CD_W-1:0] cd_rotl(input logic [CD_W-1:0] cd, input logic [1:0] n);
        return {rotl28(cd[CD_W-1:HALF_W], n), rotl28(cd[HALF_W-1:0], n)};
    endfunction

    function automatic logic [CD_W-1:0] cd_rotr(input logic [CD_W-1:0] cd, input logic [1:0] n);
        return {rotr28(cd[CD_W-1:HALF_W], n), rotr28(cd[HALF_W-1:0], n)};
    endfunction

    des_pc_perm #(.IN_W(KEY_W), .OUT_W(CD_W), .TBL(PC1_TBL)) u_pc1 (
        .din  (key_in),
        .dout (cd0)
    );

    // PC-2 sees the next C/D so the subkey is registered alongside it.
    des_pc_perm #(.IN_W(CD_W), .OUT_W(SK_W), .TBL(PC2_TBL)) u_pc2 (
        .din  (cd_d),
        .dout (sk_next)
    );

`ifdef DES_KEY_PARITY_CHECK_EN
    logic key_err_q, key_err_d;

    always_comb begin
        key_ok = 1'b1;
        for (int b = 0; b < KEY_W / 8; b++) begin
            if (!(^key_in[b*8 +: 8])) key_ok = 1'b0;
        end
    end
`else
    assign key_ok = 1'b1;
`endif

    assign nxt = cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        cd_d       = cd_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        sk_valid_d = sk_valid_q;
        sk_round_d = sk_round_q;
        sk_last_d  = sk_last_q;
        upd        = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
        key_err_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    if (key_ok) begin
                        state_d    = RUN;
                        mode_d     = decrypt;
                        cnt_d      = 4'd0;
                        // Decrypt starts from CD16, which equals CD0 after the full 28-bit cycle.
                        cd_d       = decrypt ? cd0 : cd_rotl(cd0, shift_amt(4'd0));
                        sk_valid_d = 1'b1;
                        sk_round_d = decrypt ? 4'd15 : 4'd0;
                        sk_last_d  = 1'b0;
                        upd        = 1'b1;
                    end
`ifdef DES_KEY_PARITY_CHECK_EN
                    else begin
                        key_err_d = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                if (sk_ready) begin
                    if (sk_last_q) begin
                        state_d    = IDLE;
                        sk_valid_d = 1'b0;
                        sk_last_d  = 1'b0;
                    end else begin
                        cnt_d      = nxt;
                        cd_d       = mode_q ? cd_rotr(cd_q, shift_amt(4'(5'd16 - 5'(nxt))))
                                            : cd_rotl(cd_q, shift_amt(nxt));
                        sk_round_d = mode_q ? (4'd15 - nxt) : nxt;
                        sk_last_d  = (nxt == 4'd15);
                        upd        = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sk_out_d = upd ? sk_next : sk_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cd_q       <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            sk_valid_q <= 1'b0;
            sk_out_q   <= '0;
            sk_round_q <= '0;
            sk_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cd_q       <= cd_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            sk_valid_q <= sk_valid_d;
            sk_out_q   <= sk_out_d;
            sk_round_q <= sk_round_d;
            sk_last_q  <= sk_last_d;
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_err_q <= 1'b0;
        else        key_err_q <= key_err_d;
    end

    assign key_err = key_err_q;
`endif

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign sk_valid  = sk_valid_q;
    assign sk_out    = sk_out_q;
    assign sk_round  = sk_round_q;
    assign sk_last   = sk_last_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: directed and random keys against a
// bit-level DES key-schedule model; covers ordering, stalls, reloads and reset.
module tb_des_key_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] key_in = '0;
    logic        key_valid = 1'b0;
    logic        decrypt = 1'b0;
    logic        sk_ready = 1'b1;
    logic        key_ready, sk_valid, sk_last, busy;
    logic [47:0] sk_out;
    logic [3:0]  sk_round;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic        key_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    int PC1_T[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                      10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                      63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                      14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int PC2_T[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                      23,19,12,4,26,8, 16,7,27,20,13,2,
                      41,52,31,37,47,55, 30,40,51,45,33,48,
                      44,49,39,56,34,53, 46,42,50,36,29,32};

    logic [47:0] exp_k[16];
    logic [47:0] first_sk, last_sk;
    localparam logic [63:0] KNOWN = 64'h133457799BBCDFF1;

    des_key_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .decrypt   (decrypt),
        .sk_valid  (sk_valid),
        .sk_ready  (sk_ready),
        .sk_out    (sk_out),
        .sk_round  (sk_round),
        .sk_last   (sk_last),
`ifdef DES_KEY_PARITY_CHECK_EN
        .key_err   (key_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Textbook key schedule: PC-1, sixteen rounds of single-bit rotates, PC-2.
    task automatic model(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 1; r <= 16; r++) begin
            int s;
            s = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
            for (int k = 0; k < s; k++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) exp_k[r-1][47-i] = cd[56-PC2_T[i]];
        end
    endtask

    function automatic logic [63:0] fix_parity(input logic [63:0] k);
        logic [63:0] r;
        r = k;
        for (int b = 0; b < 8; b++) r[b*8] = ~(^r[b*8+1 +: 7]);
        return r;
    endfunction

    task automatic run_seq(input logic [63:0] key, input logic dec, input int stall_j, input int midkey_j);
        model(key);
        chk("key_ready_idle", {63'd0, key_ready}, 64'd1);
        key_in    = key;
        decrypt   = dec;
        key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom};
        decrypt   = ~dec;
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("key_err_good", {63'd0, key_err}, 64'd0);
`endif
        for (int j = 0; j < 16; j++) begin
            logic [47:0] e;
            logic [3:0]  er;
            e  = dec ? exp_k[15-j] : exp_k[j];
            er = dec ? 4'(15 - j) : 4'(j);
            chk("sk_valid", {63'd0, sk_valid}, 64'd1);
            chk("sk_out", {16'd0, sk_out}, {16'd0, e});
            chk("sk_round", {60'd0, sk_round}, {60'd0, er});
            chk("sk_last", {63'd0, sk_last}, (j == 15) ? 64'd1 : 64'd0);
            chk("key_ready_run", {63'd0, key_ready}, 64'd0);
            chk("busy_run", {63'd0, busy}, 64'd1);
            if (j == 0)  first_sk = sk_out;
            if (j == 15) last_sk  = sk_out;
            if (j == stall_j) begin
                sk_ready = 1'b0;
                repeat (3) begin
                    tick;
                    chk("stall_out", {16'd0, sk_out}, {16'd0, e});
                    chk("stall_round", {60'd0, sk_round}, {60'd0, er});
                    chk("stall_valid", {63'd0, sk_valid}, 64'd1);
                end
                sk_ready = 1'b1;
            end
            if (j == midkey_j) begin
                key_in    = fix_parity({$urandom, $urandom});
                key_valid = 1'b1;
                #1;
                chk("key_ready_midkey", {63'd0, key_ready}, 64'd0);
            end
            tick;
            key_valid = 1'b0;
        end
        chk("done_valid", {63'd0, sk_valid}, 64'd0);
        chk("done_key_ready", {63'd0, key_ready}, 64'd1);
        chk("done_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] k;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sk_valid", {63'd0, sk_valid}, 64'd0);
        chk("rst_sk_out", {16'd0, sk_out}, 64'd0);
        chk("rst_sk_round", {60'd0, sk_round}, 64'd0);
        chk("rst_sk_last", {63'd0, sk_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_key_ready", {63'd0, key_ready}, 64'd1);
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("rst_key_err", {63'd0, key_err}, 64'd0);
`endif
        rst_n = 1'b1;
        tick;

        run_seq(KNOWN, 1'b0, -1, -1);
        chk("enc_first_known", {16'd0, first_sk}, 64'h1B02EFFC7072);
        chk("enc_last_known", {16'd0, last_sk}, 64'hCB3D8B0E17F5);

        run_seq(KNOWN, 1'b1, -1, -1);
        chk("dec_first_known", {16'd0, first_sk}, 64'hCB3D8B0E17F5);
        chk("dec_last_known", {16'd0, last_sk}, 64'h1B02EFFC7072);

        run_seq(KNOWN, 1'b0, 4, -1);
        run_seq(KNOWN, 1'b0, -1, 7);

        for (int n = 0; n < 6; n++) begin
            run_seq(fix_parity({$urandom, $urandom}), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        // Reset in the middle of a sequence, then a fresh load.
        k = fix_parity({$urandom, $urandom});
        key_in    = k;
        decrypt   = 1'b0;
        key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        repeat (9) tick;
        chk("pre_reset_round", {60'd0, sk_round}, 64'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sk_valid", {63'd0, sk_valid}, 64'd0);
        chk("midrst_key_ready", {63'd0, key_ready}, 64'd1);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_sk_out", {16'd0, sk_out}, 64'd0);
        chk("midrst_sk_round", {60'd0, sk_round}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("postrst_sk_valid", {63'd0, sk_valid}, 64'd0);
        chk("postrst_key_ready", {63'd0, key_ready}, 64'd1);
        run_seq(fix_parity({$urandom, $urandom}), 1'b0, -1, -1);

`ifdef DES_KEY_PARITY_CHECK_EN
        key_in    = 64'h0;
        key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        chk("par_key_err", {63'd0, key_err}, 64'd1);
        chk("par_sk_valid", {63'd0, sk_valid}, 64'd0);
        chk("par_key_ready", {63'd0, key_ready}, 64'd1);
        chk("par_busy", {63'd0, busy}, 64'd0);
        tick;
        chk("par_key_err_pulse", {63'd0, key_err}, 64'd0);
        chk("par_sk_valid2", {63'd0, sk_valid}, 64'd0);
        run_seq(KNOWN, 1'b0, -1, -1);
        chk("par_enc_first", {16'd0, first_sk}, 64'h1B02EFFC7072);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
